// File: rtl/ook_frame_decoder.sv
// Pulse-width OOK frame decoder: synchronises and deglitches the receiver envelope,
// measures filtered pulse widths and assembles FRAME_BITS-bit words (first bit in MSB).
//
// state | meaning
// IDLE  | measuring the low run, waiting for a full gap
// ARMED | gap seen, waiting for the first rising edge
// HIGH  | inside a carrier pulse, classified on its falling edge
// LOW   | between pulses, checked for too-short or too-long low
module ook_frame_decoder #(
  parameter int CHIP_CYCLES = 4800,
  parameter int FRAME_BITS  = 24,
  parameter int GAP_CHIPS   = 10,
  parameter int FILT_CYCLES = 16
) (
  input  logic                  ref_12mhz,
  input  logic                  rst,
  input  logic                  rf_in,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int WMAX    = 3 * CHIP_CYCLES;
  localparam int WW      = $clog2(WMAX + 1);
  localparam int GAP_CYC = GAP_CHIPS * CHIP_CYCLES;
  localparam int GW      = $clog2(GAP_CYC + 1);
  localparam int FW      = $clog2(FILT_CYCLES + 1);
  localparam int BW      = $clog2(FRAME_BITS + 1);

  localparam logic [WW-1:0] W_SAT   = WW'(WMAX);
  localparam logic [WW-1:0] W_MIN   = WW'(CHIP_CYCLES / 2);
  localparam logic [WW-1:0] W_SPLIT = WW'(3 * CHIP_CYCLES / 2);
  localparam logic [WW-1:0] W_MAX   = WW'(5 * CHIP_CYCLES / 2);
  localparam logic [GW-1:0] G_LAST  = GW'(GAP_CYC - 1);
  localparam logic [FW-1:0] F_LAST  = FW'(FILT_CYCLES - 1);
  localparam logic [BW-1:0] B_LAST  = BW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_HIGH, S_LOW} state_t;

  state_t                state, state_nxt;
  logic                  sync1, sync2, filt, filt_d;
  logic [FW-1:0]         fcnt;
  logic [WW-1:0]         wcnt;
  logic [GW-1:0]         gcnt;
  logic [BW-1:0]         bcnt;
  logic [FRAME_BITS-1:0] sreg, sreg_nxt;
  logic                  rise, fall, bit_in;
  logic                  valid_nxt, err_nxt, arm_clr, shift_en;

  assign rise   = filt & ~filt_d;
  assign fall   = ~filt & filt_d;
  assign bit_in = (wcnt >= W_SPLIT);
  assign busy   = (state == S_HIGH) || (state == S_LOW);

  always_comb begin
    state_nxt   = state;
    valid_nxt   = 1'b0;
    err_nxt     = 1'b0;
    arm_clr     = 1'b0;
    shift_en    = 1'b0;
    sreg_nxt    = sreg << 1;
    sreg_nxt[0] = bit_in;
    case (state)
      S_IDLE: begin
        if (!filt && gcnt == G_LAST) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (rise) begin
          arm_clr   = 1'b1;
          state_nxt = S_HIGH;
        end
      end
      S_HIGH: begin
        if (fall) begin
          if (wcnt < W_MIN || wcnt >= W_MAX) begin
            err_nxt   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            shift_en = 1'b1;
            if (bcnt == B_LAST) begin
              valid_nxt = 1'b1;
              state_nxt = S_IDLE;
            end else begin
              state_nxt = S_LOW;
            end
          end
        end
      end
      S_LOW: begin
        if (rise) begin
          if (wcnt < W_MIN) begin
            err_nxt   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_HIGH;
          end
        end else if (wcnt >= W_MAX) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ref_12mhz) begin
    if (rst) begin
      state       <= S_IDLE;
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      filt        <= 1'b0;
      filt_d      <= 1'b0;
      fcnt        <= '0;
      wcnt        <= '0;
      gcnt        <= '0;
      bcnt        <= '0;
      sreg        <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      sync1  <= rf_in;
      sync2  <= sync1;
      filt_d <= filt;
      if (sync2 != filt) begin
        if (fcnt == F_LAST) begin
          filt <= sync2;
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end else begin
        fcnt <= '0;
      end
      if (rise || fall) wcnt <= WW'(1);
      else if (wcnt != W_SAT) wcnt <= wcnt + 1'b1;
      // gap counter only runs in IDLE, so every return to IDLE demands a fresh gap
      if (state != S_IDLE || filt) gcnt <= '0;
      else if (gcnt != G_LAST) gcnt <= gcnt + 1'b1;
      if (arm_clr) begin
        bcnt <= '0;
        sreg <= '0;
      end else if (shift_en) begin
        bcnt <= bcnt + 1'b1;
        sreg <= sreg_nxt;
      end
      if (valid_nxt) frame_data <= sreg_nxt;
      state       <= state_nxt;
      frame_valid <= valid_nxt;
      frame_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_ook_frame_decoder.sv
// Bench for ook_frame_decoder: directed scenarios plus randomized frames,
// outcomes predicted from the symbol width rules applied to the driven pulse list.
module tb_ook_frame_decoder;
  localparam int CHIP = 8, FB = 8, GAP = 4, FILT = 2;
  localparam int MIN = CHIP / 2, SPLIT = 3 * CHIP / 2, MAX = 5 * CHIP / 2;
  localparam int LAG = 2 + FILT + 1;

  logic          clk = 1'b0, rst = 1'b1, rf_in = 1'b0;
  logic [FB-1:0] frame_data;
  logic          frame_valid, frame_err, busy;

  ook_frame_decoder #(.CHIP_CYCLES(CHIP), .FRAME_BITS(FB), .GAP_CHIPS(GAP), .FILT_CYCLES(FILT)) dut (
    .ref_12mhz(clk), .rst(rst), .rf_in(rf_in), .frame_data(frame_data),
    .frame_valid(frame_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0, n_fail = 0;
  int nval = 0, nerr = 0, ecyc = 0;
  bit both = 0;
  always @(negedge clk) if (!rst) begin
    if (frame_valid) nval++;
    if (frame_err) begin nerr++; ecyc = cyc; end
    if (frame_valid && frame_err) both = 1;
  end

  int hi_w[FB], lo_w[FB], fall_cyc[FB];
  logic mid_busy;
  logic [FB-1:0] exp_data = '0;
  int ev, ee, v0, e0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    rf_in = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_bits(input logic [FB-1:0] d, input bit jitter);
    for (int i = 0; i < FB; i++) begin
      if (d[FB-1-i]) begin
        hi_w[i] = jitter ? $urandom_range(13, 18) : 16;
        lo_w[i] = jitter ? $urandom_range(5, 10) : 8;
      end else begin
        hi_w[i] = jitter ? $urandom_range(5, 10) : 8;
        lo_w[i] = jitter ? $urandom_range(13, 18) : 16;
      end
    end
  endtask

  // reference: apply the width rules to the pulse list of an armed frame
  task automatic predict(input int nbits, input int tail, output int pv, output int pe);
    logic [FB-1:0] acc;
    int l;
    pv = 0; pe = 0; acc = '0;
    for (int i = 0; i < nbits; i++) begin
      if (hi_w[i] < MIN || hi_w[i] >= MAX) begin pe = 1; return; end
      acc = {acc[FB-2:0], hi_w[i] >= SPLIT};
      if (i == FB - 1) begin pv = 1; exp_data = acc; return; end
      l = (i == nbits - 1) ? tail : lo_w[i];
      if (l < MIN || l >= MAX) begin pe = 1; return; end
    end
  endtask

  task automatic send(input int nbits, input int gap, input int tail, input bit glitch, input int rst_bit);
    if (glitch) begin
      drive(0, gap / 3); drive(1, 1); drive(0, gap - gap / 3 - 1);
    end else begin
      drive(0, gap);
    end
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        drive(1, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_data", frame_data, 0);
        check("rst_valid", frame_valid, 0);
        check("rst_err", frame_err, 0);
        check("rst_busy", busy, 0);
        drive(1, hi_w[i] - 4);
      end else if (glitch) begin
        drive(1, hi_w[i] / 2); drive(0, 1); drive(1, hi_w[i] - hi_w[i] / 2 - 1);
      end else begin
        drive(1, hi_w[i]);
      end
      if (i == 3) mid_busy = busy;
      fall_cyc[i] = cyc;
      drive(0, (i == nbits - 1) ? tail : lo_w[i]);
    end
  endtask

  task automatic outcome(input string tag, input int xv, input int xe);
    check({tag, "_valid_cnt"}, nval - v0, xv);
    check({tag, "_err_cnt"}, nerr - e0, xe);
    check({tag, "_data"}, frame_data, exp_data);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int fault, k;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", frame_data, 0);
    check("reset_valid", frame_valid, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_err", frame_err, 0);

    // clean frame
    set_bits(8'hB2, 0);
    v0 = nval; e0 = nerr;
    predict(FB, 10, ev, ee);
    send(FB, 40, 10, 0, -1);
    check("clean_exp", exp_data, 8'hB2);
    check("clean_midbusy", mid_busy, 1);
    outcome("clean", ev, ee);

    // glitches in the gap and inside high pulses
    v0 = nval; e0 = nerr;
    send(FB, 40, 10, 1, -1);
    outcome("glitch", 1, 0);

    // third high pulse too wide
    set_bits(8'h6C, 0);
    hi_w[2] = 24;
    v0 = nval; e0 = nerr;
    predict(FB, 10, ev, ee);
    send(FB, 40, 10, 0, -1);
    outcome("badw", ev, ee);
    check("badw_errcnt_model", ee, 1);
    check("badw_timing", ecyc - fall_cyc[2], LAG);

    // carrier removed after bit 5
    set_bits(8'hF0, 0);
    v0 = nval; e0 = nerr;
    predict(5, 40, ev, ee);
    send(5, 40, 40, 0, -1);
    outcome("tmo", ev, ee);
    check("tmo_timing", ecyc - fall_cyc[4], LAG + MAX);
    set_bits(8'h3C, 0);
    v0 = nval; e0 = nerr;
    predict(FB, 8, ev, ee);
    send(FB, 32, 8, 0, -1);
    outcome("tmo_next", ev, ee);
    check("tmo_next_data", frame_data, 8'h3C);

    // only 24 low cycles before the frame
    set_bits(8'hA5, 0);
    v0 = nval; e0 = nerr;
    send(FB, 16, 40, 0, -1);
    check("nogap_midbusy", mid_busy, 0);
    outcome("nogap", 0, 0);

    // synchronous reset during bit 4
    set_bits(8'h96, 0);
    v0 = nval; e0 = nerr;
    exp_data = '0;
    send(FB, 40, 10, 0, 4);
    outcome("rstmid", 0, 0);
    set_bits(8'h4E, 0);
    v0 = nval; e0 = nerr;
    predict(FB, 10, ev, ee);
    send(FB, 40, 10, 0, -1);
    outcome("rst_next", ev, ee);

    // randomized frames with occasional width faults
    for (int r = 0; r < 12; r++) begin
      set_bits(FB'($urandom), 1);
      fault = $urandom_range(0, 3);
      k = $urandom_range(0, FB - 2);
      if (fault == 1) hi_w[k] = $urandom_range(20, 26);
      else if (fault == 2) hi_w[k] = $urandom_range(2, 3);
      else if (fault == 3) lo_w[k] = ($urandom_range(0, 1) == 1) ? $urandom_range(22, 28) : $urandom_range(2, 3);
      v0 = nval; e0 = nerr;
      predict(FB, 10, ev, ee);
      send(FB, 40, 10, 0, -1);
      outcome("rand", ev, ee);
    end

    check("never_both", both, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
